// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for a single-clock FIFO with one-cycle read latency.
// Starts a burst at a high-water mark and streams words out through a 4-entry credit buffer.
module fifo_burst_reader #(
    parameter int unsigned        DATA_W    = 8,
    parameter int unsigned        USEDW_W   = 8,
    parameter logic [USEDW_W-1:0] HI_WM     = 8'd192,
    parameter logic [8:0]         MAX_BURST = 9'd256
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               full,
    input  logic               empty,
    input  logic [USEDW_W-1:0] usedw,
    input  logic [DATA_W-1:0]  fifo_q,
    output logic               rd_req,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               burst_done,
    output logic [8:0]         burst_len
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [8:0]         rd_cnt;
    logic               rd_req_d;
    logic [DATA_W-1:0]  buf_mem [4];
    logic [1:0]         wr_ptr;
    logic [1:0]         rd_ptr;
    logic [2:0]         occ;
    logic               trigger;
    logic               credit_ok;
    logic               buf_wr;
    logic               buf_rd;

    assign trigger   = full || (usedw >= HI_WM);
    // A read issued now lands two cycles later, so in-flight reads count against the 4 slots.
    assign credit_ok = (occ + {2'b00, rd_req_d}) <= 3'd3;
    assign buf_wr    = rd_req_d;
    assign buf_rd    = out_valid && out_ready;

    always_comb begin
        state_nxt  = state;
        rd_req     = 1'b0;
        busy       = (state != IDLE);
        burst_done = (state == DONE);
        out_valid  = (occ != 3'd0);
        out_data   = buf_mem[rd_ptr];
        case (state)
            IDLE: begin
                if (trigger) state_nxt = BURST;
            end
            BURST: begin
                rd_req = !empty && credit_ok && (rd_cnt < MAX_BURST);
                if (empty || (rd_cnt == MAX_BURST)) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (!rd_req_d && (occ == 3'd0)) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            rd_req_d  <= 1'b0;
            rd_cnt    <= '0;
            burst_len <= '0;
        end else begin
            state    <= state_nxt;
            rd_req_d <= rd_req;
            if ((state == IDLE) && trigger) begin
                rd_cnt <= '0;
            end else if (rd_req) begin
                rd_cnt <= rd_cnt + 9'd1;
            end
            // Loaded on entry to DONE so the count is already visible alongside burst_done.
            if ((state == FLUSH) && (state_nxt == DONE)) begin
                burst_len <= rd_cnt;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                buf_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (buf_wr) begin
                buf_mem[wr_ptr] <= fifo_q;
                wr_ptr          <= wr_ptr + 2'd1;
            end
            if (buf_rd) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({buf_wr, buf_rd})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench: a full-size reader and a 16-word-burst reader, each on a behavioural FIFO,
// checked every cycle against a word-order, latency, trigger and burst-count model.
module tb_fifo_burst_reader;

    localparam int N     = 2;
    localparam int LOGSZ = 4096;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic       full_s  [N] = '{1'b0, 1'b0};
    logic       empty_s [N] = '{1'b1, 1'b1};
    logic [7:0] usedw_s [N] = '{8'd0, 8'd0};
    logic [7:0] q_s     [N] = '{8'd0, 8'd0};

    logic       rd_req0, rd_req1, out_valid0, out_valid1, busy0, busy1, done0, done1;
    logic [7:0] out_data0, out_data1;
    logic [8:0] len0, len1;
    logic       rdy0, rdy1, wr_en0;
    int         load_n [N];

    int         n_checks = 0;
    int         n_errors = 0;
    int         exp_len [N];
    int         exp_run [N];
    int         tmo_flag = 0;
    int         tmo_seen = 0;
    logic       fin_req  = 1'b0;
    logic       fin_done = 1'b0;

    fifo_burst_reader #(.DATA_W(8), .USEDW_W(8), .HI_WM(8'd192), .MAX_BURST(9'd256)) u_dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .full(full_s[0]), .empty(empty_s[0]),
        .usedw(usedw_s[0]), .fifo_q(q_s[0]), .rd_req(rd_req0), .out_data(out_data0),
        .out_valid(out_valid0), .out_ready(rdy0), .busy(busy0), .burst_done(done0),
        .burst_len(len0)
    );

    fifo_burst_reader #(.DATA_W(8), .USEDW_W(8), .HI_WM(8'd128), .MAX_BURST(9'd16)) u_dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .full(full_s[1]), .empty(empty_s[1]),
        .usedw(usedw_s[1]), .fifo_q(q_s[1]), .rd_req(rd_req1), .out_data(out_data1),
        .out_valid(out_valid1), .out_ready(rdy1), .busy(busy1), .burst_done(done1),
        .burst_len(len1)
    );

    function automatic int hiwm(input int i);
        return (i == 0) ? 192 : 128;
    endfunction

    // Behavioural FIFO: 256 deep, registered flags, data one cycle after the read request.
    logic [7:0] mem  [N][256];
    logic [7:0] wlog [N][LOGSZ];
    int         rp [N];
    int         wp [N];
    int         cnt [N];
    int         wcnt [N];

    task automatic push(input int i, input logic [7:0] d);
        mem[i][wp[i]] = d;
        wp[i] = (wp[i] + 1) % 256;
        cnt[i]++;
        if (wcnt[i] < LOGSZ) wlog[i][wcnt[i]] = d;
        wcnt[i]++;
    endtask

    always @(posedge sys_clk) begin
        logic rq;
        for (int i = 0; i < N; i++) begin
            rq = (i == 0) ? rd_req0 : rd_req1;
            if (rq && cnt[i] > 0) begin
                q_s[i] <= mem[i][rp[i]];
                rp[i] = (rp[i] + 1) % 256;
                cnt[i]--;
            end
            if (i == 0 && wr_en0 && cnt[i] < 256) push(i, 8'($urandom));
            for (int k = 0; k < load_n[i] && cnt[i] < 256; k++) push(i, 8'($urandom));
            full_s[i]  <= (cnt[i] == 256);
            empty_s[i] <= (cnt[i] == 0);
            usedw_s[i] <= 8'(cnt[i]);
        end
    end

    // Reference model state: words popped, words delivered, burst bookkeeping.
    int   rcnt [N];
    int   dcnt [N];
    int   breads [N];
    int   last_len [N];
    int   run [N];
    int   max_run [N];
    logic prev_rd [N];
    logic prev_busy [N];
    logic prev_trig [N];
    logic prev_done [N];

    task automatic chk(input string name, input int i, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s inst%0d: got %0d, expected %0d (t=%0t)", name, i, act, req, $time);
        end
    endtask

    task automatic cmp(input int i, input logic rd, input logic ov, input logic [7:0] od,
                       input logic bz, input logic dn, input logic [8:0] ln, input logic rdy);
        logic trig;
        int   occ_m;
        trig = full_s[i] || (int'(usedw_s[i]) >= hiwm(i));
        if (!sys_rst_n) begin
            chk("reset_outputs", i, int'({rd, ov, od, bz, dn, ln}), 0);
            dcnt[i]      = rcnt[i];
            prev_rd[i]   = 1'b0;
            prev_busy[i] = 1'b0;
            prev_done[i] = 1'b0;
            prev_trig[i] = trig;
            breads[i]    = 0;
            last_len[i]  = 0;
            run[i]       = 0;
            max_run[i]   = 0;
            return;
        end
        occ_m = rcnt[i] - int'(prev_rd[i]) - dcnt[i];
        chk("out_valid", i, int'(ov), int'(occ_m != 0));
        if (ov && rdy) begin
            if (dcnt[i] < wcnt[i]) chk("out_data", i, int'(od), int'(wlog[i][dcnt[i]]));
            else chk("extra_word", i, 1, 0);
            dcnt[i]++;
        end
        if (rd) chk("rd_when_empty", i, int'(empty_s[i]), 0);
        chk("in_flight_le4", i, int'((rcnt[i] + int'(rd) - dcnt[i]) <= 4), 1);
        if (!prev_busy[i]) chk("trigger_start", i, int'(bz), int'(prev_trig[i]));
        if (rd) chk("rd_outside_burst", i, int'(bz), 1);
        if (prev_done[i]) chk("done_pulse_idle", i, int'({bz, dn}), 0);
        if (dn) begin
            chk("done_busy", i, int'(bz), 1);
            chk("burst_len_model", i, int'(ln), breads[i]);
            if (exp_len[i] != 0) chk("burst_len_literal", i, int'(ln), exp_len[i]);
            if (exp_run[i] != 0) chk("rd_req_run", i, max_run[i], exp_run[i]);
            last_len[i] = breads[i];
            breads[i]   = 0;
            max_run[i]  = 0;
        end else begin
            chk("burst_len_hold", i, int'(ln), last_len[i]);
        end
        if (rd) begin
            run[i]++;
            if (run[i] > max_run[i]) max_run[i] = run[i];
        end else begin
            run[i] = 0;
        end
        rcnt[i]     += int'(rd);
        breads[i]   += int'(rd);
        prev_rd[i]   = rd;
        prev_busy[i] = bz;
        prev_trig[i] = trig;
        prev_done[i] = dn;
    endtask

    always @(negedge sys_clk) begin
        cmp(0, rd_req0, out_valid0, out_data0, busy0, done0, len0, rdy0);
        cmp(1, rd_req1, out_valid1, out_data1, busy1, done1, len1, rdy1);
        if (tmo_flag != tmo_seen) begin
            tmo_seen = tmo_flag;
            chk("wait_budget_expired", 0, 1, 0);
        end
        if (fin_req && !fin_done) begin
            chk("all_words_delivered", 0, dcnt[0], wcnt[0]);
            chk("fifo_empty_at_end", 0, int'(empty_s[0]), 1);
            chk("limited_bursts_total", 1, dcnt[1], 80);
            fin_done = 1'b1;
        end
    end

    task automatic load(input int n0, input int n1);
        load_n[0] = n0;
        load_n[1] = n1;
        @(posedge sys_clk); #1;
        load_n[0] = 0;
        load_n[1] = 0;
    endtask

    task automatic wait_done(input int i, input int budget, input bit rnd, input bit writer);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge sys_clk);
            seen = (i == 0) ? done0 : done1;
            #1;
            if (rnd) rdy0 = ($urandom_range(0, 3) != 0);
            wr_en0 = writer && !seen && (c % 4 == 0);
        end
        wr_en0 = 1'b0;
        rdy0   = 1'b1;
        if (!seen) tmo_flag++;
        @(posedge sys_clk); #1;
    endtask

    initial begin
        rdy1 = 1'b0;
        forever begin
            @(posedge sys_clk); #1;
            rdy1 = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        int k;
        rdy0 = 1'b0;
        wr_en0 = 1'b0;
        load_n = '{0, 0};
        exp_len = '{0, 0};
        exp_run = '{0, 0};
        repeat (4) @(negedge sys_clk);
        #1 sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // Full-FIFO drain on reader 0; 200 words behind the 16-word limit on reader 1.
        exp_len[1] = 16;
        rdy0 = 1'b1;
        exp_len[0] = 256;
        exp_run[0] = 256;
        load(256, 200);
        wait_done(0, 1000, 1'b0, 1'b0);
        exp_run[0] = 0;

        // Backpressure mid-burst.
        load(256, 0);
        repeat (30) @(negedge sys_clk);
        #1 rdy0 = 1'b0;
        repeat (20) @(negedge sys_clk);
        #1 rdy0 = 1'b1;
        wait_done(0, 1000, 1'b0, 1'b0);

        // Watermark trigger with random consumer stalls.
        exp_len[0] = 192;
        load(192, 0);
        wait_done(0, 2000, 1'b1, 1'b0);

        // Upstream writes during the burst extend it.
        exp_len[0] = 0;
        load(192, 0);
        wait_done(0, 2000, 1'b0, 1'b1);

        // Reset after 50 reads of a fresh burst, then the leftover words retrigger.
        load(256, 0);
        k = 0;
        for (int c = 0; c < 600 && k < 50; c++) begin
            @(negedge sys_clk);
            if (rd_req0) k++;
        end
        if (k < 50) tmo_flag++;
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        #1 sys_rst_n = 1'b1;
        wait_done(0, 2000, 1'b0, 1'b0);

        fin_req = 1'b1;
        repeat (4) @(posedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side controller for the 8-bit, 256-deep single-clock FIFO (normal mode, one-cycle read latency). It watches the FIFO status flags and starts a read burst when the FIFO reaches a high-water mark or fills. It then issues `rd_req` until the FIFO is empty or a burst limit is reached, and delivers the words in order on a valid/ready output stream through an internal 4-entry buffer. It sits directly on the FIFO's `rd_req`, `empty`, `full`, `usedw` and `q` pins and feeds the downstream consumer.

## Interface
- `DATA_W`, 8, FIFO word width.
- `USEDW_W`, 8, width of the FIFO `usedw` count (depth 2^USEDW_W).
- `HI_WM`, 8'd192, burst starts when `usedw >= HI_WM` or `full`.
- `MAX_BURST`, 9'd256, maximum words per burst (1..256).
- `sys_clk`  in  1  clock; all logic on the rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `full`  in  1  FIFO full flag.
- `empty`  in  1  FIFO empty flag.
- `usedw`  in  USEDW_W  FIFO fill count (reads 0 when full).
- `fifo_q`  in  DATA_W  FIFO read data, valid the cycle after `rd_req`.
- `rd_req`  out  1  FIFO read request.
- `out_data`  out  DATA_W  head word of the output buffer.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready`.
- `busy`  out  1  state is not IDLE.
- `burst_done`  out  1  one-cycle pulse at the end of a burst.
- `burst_len`  out  9  words read in the last completed burst; held until the next `burst_done`.

## Operation
- **States:** IDLE, BURST, FLUSH, DONE. State is registered and encoded as 2 bits.
- **IDLE → BURST:** when `full || usedw >= HI_WM`. `rd_cnt` clears to 0 on entry.
- **BURST:**
  - `rd_req = !empty && (occ + rd_req_d <= 3) && (rd_cnt < MAX_BURST)`. This is combinational from registered state, the FIFO flags and the occupancy.
  - `rd_req_d` is `rd_req` registered.
  - `rd_cnt` increments on every `rd_req`.
- **BURST → FLUSH:** at the first clock where `empty == 1` or `rd_cnt == MAX_BURST`. No further `rd_req` is issued after leaving BURST.
- **FLUSH → DONE:** when `rd_req_d == 0 && occ == 0`, i.e. there is no in-flight read and the buffer has drained.
- **DONE:**
  - `burst_done` is high and `burst_len` is loaded from `rd_cnt`.
  - DONE → IDLE on the next clock unconditionally.
  - A new burst needs the trigger condition again while in IDLE; there is no restart directly from DONE.
- **Output buffer:**
  - 4-entry circular buffer with 2-bit wr/rd pointers and a 3-bit `occ` count.
  - Write when `rd_req_d == 1`, storing `fifo_q`.
  - Read when `out_valid && out_ready`.
  - Simultaneous write and read leave `occ` unchanged.
  - Pointers wrap 3 → 0.
  - `out_valid = (occ != 0)`; `out_data` is the entry at the read pointer.
- **Overflow:** the credit rule guarantees `occ <= 4` with `out_ready` held low indefinitely. No word is lost or duplicated, and FIFO order is preserved.
- **Underflow:** `rd_req` is never high while `empty == 1`.
- **`rd_cnt` width:** 9 bits, so that 256 is representable.

## Timing
- **Reset values:** `rd_req`=0, `out_valid`=0, `out_data`=0, `busy`=0, `burst_done`=0, `burst_len`=0. State = IDLE, `occ`=0, pointers=0, `rd_cnt`=0, `rd_req_d`=0.
- **Reset assertion:** clears everything immediately, including mid-burst; buffered words are discarded.
- **Trigger latency:** the trigger is sampled at edge N; `rd_req` can be high in the cycle after edge N.
- **Read latency:** `rd_req` high in cycle t → word written to the buffer at the end of t+1 → `out_valid` high in t+2.
- **Throughput:** with `out_ready` held at 1, `rd_req` stays high every cycle of the burst. After the first word, one word per cycle is delivered.
- **`busy`:** high from the first BURST cycle through the DONE cycle.
- **Concurrent writes:** upstream writes during BURST extend the burst; `empty` is re-evaluated every cycle.

## Test plan
- **Full-FIFO drain:** write 0..255 into the FIFO, `out_ready`=1 → `rd_req` high for 256 consecutive cycles, `out_data` sequence 0..255, one `burst_done` pulse, `burst_len`=256, FIFO `empty`.
- **Backpressure:** during a burst hold `out_ready`=0 for 20 cycles, then release → `occ` stops at 4 and `rd_req` goes low within 2 cycles. The stream then continues with no gap or duplicate in the sequence, and `burst_len`=256.
- **Watermark trigger:** write 192 words (`full`=0) → BURST entered the next cycle, 192 words delivered in order, `burst_len`=192.
- **Concurrent writes:** writer adds one word every 4 cycles during the burst → burst continues until `empty`, and `burst_len` equals 192 plus the words written before `empty` was seen.
- **Burst limit:** `MAX_BURST`=16 with 200 words stored → exactly 16 `rd_req` pulses and `burst_len`=16. The next burst starts on the following IDLE cycle because `usedw`=184 is not below `HI_WM`.
- **Reset mid-burst:** assert `sys_rst_n`=0 after 50 reads → all outputs 0 and `busy`=0 immediately. After release, the block stays IDLE until the trigger is seen again.
